vending_ctrl_multi: RTL and testbench
=====================================

# vending_ctrl_multi

Parametrised multi-product beverage vending controller: the next generation of the single-price coin FSM. It accumulates credit from 5/10/50 coin pulses and vends one of N_PROD products, each with its own price. It returns change serially as one pulse per 5-unit coin and supports cancel/refund with overflow coin rejection. It sits between the coin acceptor and selection-panel front end and the dispenser and change-hopper drivers. All money values are in units of 5.

## Interface

Parameters:
- CREDIT_W, 8: width of the credit register, in 5-units.
- N_PROD, 4: number of products.
- SEL_W, 2: selection index width, must be at least clog2(N_PROD).
- PRICE_LIST, {8'd10, 8'd5, 8'd4, 8'd3}: packed prices, with product i at bits [i*CREDIT_W +: CREDIT_W], in 5-units. Defaults are 15/20/25/50 for products 0..3.
- MAX_CREDIT, 20: maximum credit held, in 5-units (100).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- coin_5, in, 1: 1-cycle pulse, adds 1 unit.
- coin_10, in, 1: 1-cycle pulse, adds 2 units.
- coin_50, in, 1: 1-cycle pulse, adds 10 units.
- sel_valid, in, 1: product selection strobe.
- sel_id, in, SEL_W: selected product index.
- cancel, in, 1: refund request.
- dispense, out, 1: 1-cycle vend pulse.
- disp_id, out, SEL_W: product vended; valid while dispense is high.
- change_pulse, out, 1: one pulse per returned 5-unit coin.
- credit, out, CREDIT_W: current credit.
- busy, out, 1: high in VEND and CHANGE.
- coin_reject, out, 1: 1-cycle pulse; the coins sampled on the previous edge were refused.
- sel_err, out, 1: 1-cycle pulse; the selection was refused.

## Operation

The state machine has three states: COLLECT, VEND and CHANGE.

COLLECT:
- Coins: the coin sum for the edge is 1·coin_5 + 2·coin_10 + 10·coin_50. Simultaneous coins are summed.
- If credit + sum ≤ MAX_CREDIT, credit is loaded with credit + sum.
- Otherwise the whole cycle's coins are refused: credit is unchanged and coin_reject is asserted.
- Cancel: cancel with credit > 0 moves to CHANGE with the full credit refunded.
- cancel with credit = 0 is ignored.
- cancel has priority over sel_valid and over coins in the same cycle. Those coins are rejected, and coin_reject is asserted if any coin was present.
- Selection: sel_valid with sel_id ≥ N_PROD, or with credit < PRICE[sel_id], asserts sel_err. State and credit are unchanged.
- sel_valid with credit ≥ PRICE[sel_id] (all of the following on that edge):
  - state goes to VEND;
  - dispense = 1;
  - disp_id = sel_id;
  - credit is loaded with credit − PRICE[sel_id].
- Coins arriving in the same cycle as an accepted selection are rejected, with coin_reject asserted.

VEND (exactly 1 cycle):
- Next state is CHANGE if credit > 0, else COLLECT.

CHANGE:
- change_pulse is asserted for exactly N consecutive cycles, where N is the credit on entry.
- credit decrements by 1 on each pulse edge.
- The machine returns to COLLECT when credit reaches 0.

While busy:
- Every coin is rejected: coin_reject is asserted and credit is unaffected.
- sel_valid asserts sel_err.
- cancel is ignored.

Arithmetic:
- The coin sum and the comparison use CREDIT_W+1 bits, so credit + sum never wraps.
- credit never exceeds MAX_CREDIT and never underflows.

## Timing

- All outputs are registered. There is no combinational path from input to output.
- Reset values: state COLLECT, credit 0; dispense, disp_id, change_pulse, busy, coin_reject and sel_err all 0. Reset is applied at any edge with rst = 1 and overrides every other input.
- Coin latency: a coin sampled at edge k is reflected in credit after edge k.
- coin_reject and sel_err are high for the one cycle following the offending edge.
- Vend sequence:
  - sel_valid accepted at edge k.
  - After edge k: dispense is high for cycle k+1 and busy is high.
  - change_pulse is high for cycles k+2 … k+1+N.
  - After the last pulse edge: state is COLLECT, busy = 0 and credit = 0.
- Cancel sequence: cancel at edge k gives change_pulse in cycles k+1 … k+credit. dispense stays 0.
- Reset mid-CHANGE: pulses stop at the reset edge, credit is 0 and the remaining change is forfeited.
- A new sel_valid is accepted only when busy = 0 at the sampling edge.

## Test plan

- Reset: hold rst for 2 cycles with coin_5 = 1 -> all outputs 0 and credit 0. Release rst -> credit = 1 after the next coin edge.
- coin_5 ×3, then sel 0 (price 3) -> credit 1, 2, 3; one dispense with disp_id = 0; credit 0; no change_pulse; busy for 1 cycle.
- coin_10 ×2 (credit 4), then sel 0 -> dispense, then exactly 1 change_pulse; credit 4→1→0.
- coin_50 (credit 10), then sel 3 (price 10) -> dispense with disp_id = 3 and no change.
- Simultaneous coin_10 + coin_5 at credit 1 -> credit 4.
- Credit 20, then coin_5 -> coin_reject and credit stays 20.
- Coin during CHANGE -> coin_reject and the pulse count is unchanged.
- Insufficient and invalid selection:
  - Credit 2, sel 0 -> sel_err, credit 2, no dispense.
  - sel_id = 3 with N_PROD = 3 -> sel_err.
- Cancel and reset:
  - Credit 7, cancel + sel_valid in the same cycle -> 7 consecutive change_pulse and no dispense.
  - rst asserted on the 3rd pulse -> change_pulse 0 and credit 0 from the next cycle.

Source files
------------

// File: rtl/vending_ctrl_multi.sv
//------------------------------------------------------------------------------
// Module     : vending_ctrl_multi
// Description: Multi-product vending controller with coin credit, per-product
//              pricing, serial change return and cancel/refund.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vending_ctrl_multi #(
    parameter int CREDIT_W = 8,
    parameter int N_PROD   = 4,
    parameter int SEL_W    = 2,
    parameter logic [CREDIT_W*N_PROD-1:0] PRICE_LIST = {8'd10, 8'd5, 8'd4, 8'd3},
    parameter int MAX_CREDIT = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                coin_50,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    output logic                dispense,
    output logic [SEL_W-1:0]    disp_id,
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                sel_err
);

    localparam logic [CREDIT_W:0] c_max   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [SEL_W:0]    c_nprod = (SEL_W+1)'(N_PROD);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_CHANGE  = 2'd2
    } state_t;

    state_t              r_state, w_state_nx;
    logic [CREDIT_W-1:0] r_credit, w_credit_nx;
    logic                r_dispense, w_dispense_nx;
    logic [SEL_W-1:0]    r_disp_id, w_disp_id_nx;
    logic                r_change, w_change_nx;
    logic                r_busy;
    logic                r_coin_rej, w_coin_rej_nx;
    logic                r_sel_err, w_sel_err_nx;

    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_total;
    logic                w_any_coin;
    logic [CREDIT_W-1:0] w_price;
    logic                w_sel_in_range;
    logic                w_coins_blocked;

    // One extra bit keeps credit + coin sum from wrapping before the limit check
    assign w_sum = (CREDIT_W+1)'(coin_5)
                 + (CREDIT_W+1)'({coin_10, 1'b0})
                 + (coin_50 ? (CREDIT_W+1)'(10) : '0);
    assign w_total        = {1'b0, r_credit} + w_sum;
    assign w_any_coin     = coin_5 | coin_10 | coin_50;
    assign w_sel_in_range = ({1'b0, sel_id} < c_nprod);

    always_comb begin
        w_price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel_id == SEL_W'(i)) begin
                w_price = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_credit_nx     = r_credit;
        w_dispense_nx   = 1'b0;
        w_disp_id_nx    = r_disp_id;
        w_change_nx     = 1'b0;
        w_coin_rej_nx   = 1'b0;
        w_sel_err_nx    = 1'b0;
        w_coins_blocked = 1'b1;

        case (r_state)
            S_COLLECT: begin
                w_coins_blocked = 1'b0;
                if (cancel && (r_credit != '0)) begin
                    w_state_nx      = S_CHANGE;
                    w_change_nx     = 1'b1;
                    w_coins_blocked = 1'b1;
                end else if (sel_valid) begin
                    if (!w_sel_in_range || (r_credit < w_price)) begin
                        w_sel_err_nx = 1'b1;
                    end else begin
                        w_state_nx      = S_VEND;
                        w_dispense_nx   = 1'b1;
                        w_disp_id_nx    = sel_id;
                        w_credit_nx     = r_credit - w_price;
                        w_coins_blocked = 1'b1;
                    end
                end
            end
            S_VEND: begin
                w_sel_err_nx = sel_valid;
                if (r_credit != '0) begin
                    w_state_nx  = S_CHANGE;
                    w_change_nx = 1'b1;
                end else begin
                    w_state_nx = S_COLLECT;
                end
            end
            S_CHANGE: begin
                w_sel_err_nx = sel_valid;
                if (r_credit > CREDIT_W'(1)) begin
                    w_credit_nx = r_credit - CREDIT_W'(1);
                    w_change_nx = 1'b1;
                end else begin
                    w_credit_nx = '0;
                    w_state_nx  = S_COLLECT;
                end
            end
            default: begin
                w_state_nx  = S_COLLECT;
                w_credit_nx = '0;
            end
        endcase

        // Coins are only banked in COLLECT when nothing else claimed the cycle
        if (w_coins_blocked) begin
            w_coin_rej_nx = w_any_coin;
        end else if (w_total <= c_max) begin
            w_credit_nx = w_total[CREDIT_W-1:0];
        end else begin
            w_coin_rej_nx = w_any_coin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_COLLECT;
            r_credit   <= '0;
            r_dispense <= 1'b0;
            r_disp_id  <= '0;
            r_change   <= 1'b0;
            r_busy     <= 1'b0;
            r_coin_rej <= 1'b0;
            r_sel_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_credit   <= w_credit_nx;
            r_dispense <= w_dispense_nx;
            r_disp_id  <= w_disp_id_nx;
            r_change   <= w_change_nx;
            r_busy     <= (w_state_nx != S_COLLECT);
            r_coin_rej <= w_coin_rej_nx;
            r_sel_err  <= w_sel_err_nx;
        end
    end

    assign dispense     = r_dispense;
    assign disp_id      = r_disp_id;
    assign change_pulse = r_change;
    assign credit       = r_credit;
    assign busy         = r_busy;
    assign coin_reject  = r_coin_rej;
    assign sel_err      = r_sel_err;

endmodule

`default_nettype wire

// File: tb/tb_vending_ctrl_multi.sv
//------------------------------------------------------------------------------
// Module     : tb_vending_ctrl_multi
// Description: Directed self-checking bench for vending_ctrl_multi.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vending_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_5 = 1'b0, coin_10 = 1'b0, coin_50 = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       cancel = 1'b0;
    logic       dispense, change_pulse, busy, coin_reject, sel_err;
    logic [1:0] disp_id;
    logic [7:0] credit;

    logic       sel_valid3 = 1'b0;
    logic [1:0] sel_id3 = 2'd0;
    logic       dispense3, change_pulse3, busy3, coin_reject3, sel_err3;
    logic [1:0] disp_id3;
    logic [7:0] credit3;

    int checks = 0;
    int errors = 0;
    int cnt;
    int saw_disp;

    always #5 clk = ~clk;

    vending_ctrl_multi u_dut (
        .clk(clk), .rst(rst), .coin_5(coin_5), .coin_10(coin_10), .coin_50(coin_50),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .dispense(dispense), .disp_id(disp_id), .change_pulse(change_pulse),
        .credit(credit), .busy(busy), .coin_reject(coin_reject), .sel_err(sel_err)
    );

    // Three-product variant so an out-of-range index is reachable
    vending_ctrl_multi #(
        .CREDIT_W(8), .N_PROD(3), .SEL_W(2),
        .PRICE_LIST({8'd5, 8'd4, 8'd3}), .MAX_CREDIT(20)
    ) u_dut3 (
        .clk(clk), .rst(rst), .coin_5(coin_5), .coin_10(coin_10), .coin_50(coin_50),
        .sel_valid(sel_valid3), .sel_id(sel_id3), .cancel(cancel),
        .dispense(dispense3), .disp_id(disp_id3), .change_pulse(change_pulse3),
        .credit(credit3), .busy(busy3), .coin_reject(coin_reject3), .sel_err(sel_err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        coin_5 = 0; coin_10 = 0; coin_50 = 0;
        sel_valid = 0; cancel = 0; sel_valid3 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a coin present
        rst = 1; coin_5 = 1;
        tick(); tick();
        chk("rst_credit", 32'(credit), 0);
        chk("rst_dispense", 32'(dispense), 0);
        chk("rst_disp_id", 32'(disp_id), 0);
        chk("rst_change", 32'(change_pulse), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_coin_reject", 32'(coin_reject), 0);
        chk("rst_sel_err", 32'(sel_err), 0);
        rst = 0;
        tick(); coin_5 = 0;
        chk("coin5_first", 32'(credit), 1);
        coin_5 = 1; tick(); chk("coin5_second", 32'(credit), 2);
        tick(); coin_5 = 0; chk("coin5_third", 32'(credit), 3);

        // Exact price vend, no change
        sel_valid = 1; sel_id = 0; tick(); clr();
        chk("vend0_dispense", 32'(dispense), 1);
        chk("vend0_id", 32'(disp_id), 0);
        chk("vend0_credit", 32'(credit), 0);
        chk("vend0_busy", 32'(busy), 1);
        tick();
        chk("vend0_done_busy", 32'(busy), 0);
        chk("vend0_no_change", 32'(change_pulse), 0);
        chk("vend0_disp_low", 32'(dispense), 0);

        // Vend with one unit of change
        coin_10 = 1; tick(); chk("coin10_a", 32'(credit), 2);
        tick(); clr(); chk("coin10_b", 32'(credit), 4);
        sel_valid = 1; sel_id = 0; tick(); clr();
        chk("vend1_dispense", 32'(dispense), 1);
        chk("vend1_credit", 32'(credit), 1);
        chk("vend1_change_pre", 32'(change_pulse), 0);
        tick();
        chk("vend1_change", 32'(change_pulse), 1);
        chk("vend1_busy", 32'(busy), 1);
        tick();
        chk("vend1_change_end", 32'(change_pulse), 0);
        chk("vend1_credit_end", 32'(credit), 0);
        chk("vend1_busy_end", 32'(busy), 0);

        // Highest-priced product
        coin_50 = 1; tick(); clr(); chk("coin50", 32'(credit), 10);
        sel_valid = 1; sel_id = 3; tick(); clr();
        chk("vend3_dispense", 32'(dispense), 1);
        chk("vend3_id", 32'(disp_id), 3);
        chk("vend3_credit", 32'(credit), 0);
        tick();
        chk("vend3_no_change", 32'(change_pulse), 0);

        // Simultaneous coins
        coin_5 = 1; tick(); clr();
        coin_5 = 1; coin_10 = 1; tick(); clr();
        chk("coin_sum", 32'(credit), 4);

        // Fill to the limit then overflow
        coin_50 = 1; tick(); clr();
        coin_10 = 1; tick(); tick(); tick(); clr();
        chk("credit_max", 32'(credit), 20);
        coin_5 = 1; tick(); clr();
        chk("ovf_reject", 32'(coin_reject), 1);
        chk("ovf_credit", 32'(credit), 20);
        tick();
        chk("ovf_reject_clear", 32'(coin_reject), 0);

        // Vend leaving 10 units; coin and selection during change
        sel_valid = 1; sel_id = 3; tick(); clr();
        chk("vend_big_credit", 32'(credit), 10);
        for (int j = 1; j <= 10; j++) begin
            coin_5 = (j == 3);
            sel_valid = (j == 5); sel_id = 0;
            tick(); clr();
            chk("chg_pulse", 32'(change_pulse), 1);
            chk("chg_credit", 32'(credit), 32'(11 - j));
            if (j == 3) chk("chg_coin_reject", 32'(coin_reject), 1);
            if (j == 5) chk("chg_sel_err", 32'(sel_err), 1);
        end
        tick();
        chk("chg_end_pulse", 32'(change_pulse), 0);
        chk("chg_end_busy", 32'(busy), 0);
        chk("chg_end_credit", 32'(credit), 0);

        // Insufficient credit
        coin_10 = 1; tick(); clr();
        sel_valid = 1; sel_id = 0; tick(); clr();
        chk("insuf_sel_err", 32'(sel_err), 1);
        chk("insuf_credit", 32'(credit), 2);
        chk("insuf_dispense", 32'(dispense), 0);
        chk("insuf_busy", 32'(busy), 0);

        // Out-of-range index on the three-product variant
        sel_valid3 = 1; sel_id3 = 3; tick(); clr();
        chk("invalid_sel_err", 32'(sel_err3), 1);
        chk("invalid_dispense", 32'(dispense3), 0);

        // Cancel wins over selection and coins
        coin_10 = 1; tick(); tick(); clr();
        coin_5 = 1; tick(); clr();
        chk("cancel_credit_pre", 32'(credit), 7);
        cancel = 1; sel_valid = 1; sel_id = 0; coin_5 = 1; tick(); clr();
        chk("cancel_pulse1", 32'(change_pulse), 1);
        chk("cancel_coin_reject", 32'(coin_reject), 1);
        chk("cancel_credit", 32'(credit), 7);
        cnt = 1; saw_disp = int'(dispense);
        for (int j = 0; j < 20; j++) begin
            tick();
            if (dispense) saw_disp = 1;
            if (!change_pulse) break;
            cnt++;
        end
        chk("cancel_pulse_count", 32'(cnt), 7);
        chk("cancel_no_dispense", 32'(saw_disp), 0);
        chk("cancel_end_credit", 32'(credit), 0);
        chk("cancel_end_busy", 32'(busy), 0);

        // Reset during the third change pulse
        coin_50 = 1; tick(); clr();
        cancel = 1; tick(); clr();
        chk("rc_pulse1_credit", 32'(credit), 10);
        tick(); chk("rc_pulse2_credit", 32'(credit), 9);
        tick(); chk("rc_pulse3", 32'(change_pulse), 1);
        rst = 1; tick(); rst = 0;
        chk("rc_pulse_off", 32'(change_pulse), 0);
        chk("rc_credit", 32'(credit), 0);
        chk("rc_busy", 32'(busy), 0);
        tick();
        chk("rc_forfeit", 32'(change_pulse), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
